// File: rtl/cti_commit_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cti_commit_queue : in-order CTI queue feeding retired CTIs to the RAS and
//                    branch predictors as one architectural update per cycle.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module cti_commit_queue #(
   parameter int DEPTH = 16,
   parameter int INDEX = 4,
   parameter int PC_W  = 32,
   parameter int BT_W  = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enq_i,
   input  logic [PC_W-1:0]  enqPC_i,
   input  logic [BT_W-1:0]  enqBrType_i,
   input  logic             enqPredDir_i,
   output logic [INDEX-1:0] ctiID_o,
   output logic             full_o,
   input  logic             resolveEn_i,
   input  logic [INDEX-1:0] resolveID_i,
   input  logic             resolveDir_i,
   input  logic             commitEn_i,
   input  logic             recoverFlag_i,
   input  logic [INDEX-1:0] recoverID_i,
   input  logic             exceptionFlag_i,
   output logic             updateEn_o,
   output logic [BT_W-1:0]  updateBrType_o,
   output logic [PC_W-1:0]  updatePC_o,
   output logic             updateDir_o,
   output logic             empty_o
);

   localparam logic [INDEX:0] PTR_ONE   = (INDEX+1)'(1);
   localparam logic [INDEX:0] PTR_DEPTH = (INDEX+1)'(DEPTH);

   logic [PC_W-1:0] pc_q       [DEPTH];
   logic [BT_W-1:0] bt_q       [DEPTH];
   logic            predDir_q  [DEPTH];
   logic            resDir_q   [DEPTH];
   logic            resolved_q [DEPTH];

   logic [INDEX:0]  head_q, head_d;
   logic [INDEX:0]  cmt_q,  cmt_d;
   logic [INDEX:0]  tail_q, tail_d;
   logic [INDEX:0]  occ;
   logic [INDEX:0]  recPtr;
   logic [INDEX-1:0] headIdx;

   logic            updateEn_q,  updateEn_d;
   logic [BT_W-1:0] updateBt_q,  updateBt_d;
   logic [PC_W-1:0] updatePC_q,  updatePC_d;
   logic            updateDir_q, updateDir_d;

   logic enqFire;
   logic commitFire;
   logic drain;

   assign occ     = tail_q - head_q;
   assign full_o  = (occ == PTR_DEPTH);
   assign empty_o = (tail_q == head_q);
   assign ctiID_o = tail_q[INDEX-1:0];
   assign headIdx = head_q[INDEX-1:0];

   assign enqFire    = enq_i & ~full_o & ~recoverFlag_i & ~exceptionFlag_i;
   assign commitFire = commitEn_i & (cmt_q != tail_q);
   assign drain      = (head_q != cmt_q);

   // The mispredicted entry is unretired, so it lies in [cmt, cmt+DEPTH):
   // its wrap bit flips exactly when its index is below the commit index.
   assign recPtr = {cmt_q[INDEX] ^ (recoverID_i < cmt_q[INDEX-1:0]), recoverID_i};

   always_comb begin
      cmt_d  = commitFire ? cmt_q + PTR_ONE : cmt_q;
      head_d = drain ? head_q + PTR_ONE : head_q;
      tail_d = tail_q;
      if (exceptionFlag_i) begin
         tail_d = cmt_d;
      end else if (recoverFlag_i) begin
         tail_d = recPtr + PTR_ONE;
      end else if (enqFire) begin
         tail_d = tail_q + PTR_ONE;
      end
   end

   always_comb begin
      updateEn_d  = drain;
      updateBt_d  = updateBt_q;
      updatePC_d  = updatePC_q;
      updateDir_d = updateDir_q;
      if (drain) begin
         updateBt_d  = bt_q[headIdx];
         updatePC_d  = pc_q[headIdx];
         updateDir_d = resolved_q[headIdx] ? resDir_q[headIdx] : predDir_q[headIdx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q      <= '0;
         cmt_q       <= '0;
         tail_q      <= '0;
         updateEn_q  <= 1'b0;
         updateBt_q  <= '0;
         updatePC_q  <= '0;
         updateDir_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         cmt_q       <= cmt_d;
         tail_q      <= tail_d;
         updateEn_q  <= updateEn_d;
         updateBt_q  <= updateBt_d;
         updatePC_q  <= updatePC_d;
         updateDir_q <= updateDir_d;
      end
   end

   // Entry storage is not reset: a slot is always written before it is read.
   always_ff @(posedge clk) begin
      if (resolveEn_i) begin
         resDir_q[resolveID_i]   <= resolveDir_i;
         resolved_q[resolveID_i] <= 1'b1;
      end
      if (enqFire) begin
         pc_q[ctiID_o]       <= enqPC_i;
         bt_q[ctiID_o]       <= enqBrType_i;
         predDir_q[ctiID_o]  <= enqPredDir_i;
         resolved_q[ctiID_o] <= 1'b0;
      end
   end

   assign updateEn_o     = updateEn_q;
   assign updateBrType_o = updateBt_q;
   assign updatePC_o     = updatePC_q;
   assign updateDir_o    = updateDir_q;

endmodule
`default_nettype wire

// File: tb/tb_cti_commit_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cti_commit_queue : directed bench with a queue-based reference model.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_cti_commit_queue;

   localparam int DEPTH = 16;
   localparam int INDEX = 4;
   localparam int PC_W  = 32;
   localparam int BT_W  = 2;

   localparam logic [BT_W-1:0] BT_COND   = 2'd0;
   localparam logic [BT_W-1:0] BT_CALL   = 2'd1;
   localparam logic [BT_W-1:0] BT_RETURN = 2'd2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             enq_i = 1'b0;
   logic [PC_W-1:0]  enqPC_i = '0;
   logic [BT_W-1:0]  enqBrType_i = '0;
   logic             enqPredDir_i = 1'b0;
   logic [INDEX-1:0] ctiID_o;
   logic             full_o;
   logic             resolveEn_i = 1'b0;
   logic [INDEX-1:0] resolveID_i = '0;
   logic             resolveDir_i = 1'b0;
   logic             commitEn_i = 1'b0;
   logic             recoverFlag_i = 1'b0;
   logic [INDEX-1:0] recoverID_i = '0;
   logic             exceptionFlag_i = 1'b0;
   logic             updateEn_o;
   logic [BT_W-1:0]  updateBrType_o;
   logic [PC_W-1:0]  updatePC_o;
   logic             updateDir_o;
   logic             empty_o;

   cti_commit_queue #(.DEPTH(DEPTH), .INDEX(INDEX), .PC_W(PC_W), .BT_W(BT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .enq_i(enq_i), .enqPC_i(enqPC_i), .enqBrType_i(enqBrType_i), .enqPredDir_i(enqPredDir_i),
      .ctiID_o(ctiID_o), .full_o(full_o),
      .resolveEn_i(resolveEn_i), .resolveID_i(resolveID_i), .resolveDir_i(resolveDir_i),
      .commitEn_i(commitEn_i), .recoverFlag_i(recoverFlag_i), .recoverID_i(recoverID_i),
      .exceptionFlag_i(exceptionFlag_i),
      .updateEn_o(updateEn_o), .updateBrType_o(updateBrType_o), .updatePC_o(updatePC_o),
      .updateDir_o(updateDir_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: in-flight CTIs split into retired-not-yet-drained and
   // not-yet-retired lists, in program order.
   typedef struct {
      int              id;
      logic [PC_W-1:0] pc;
      logic [BT_W-1:0] bt;
      logic            pd;
      logic            rd;
      logic            res;
   } ent_t;

   ent_t ret[$];
   ent_t pend[$];
   int   m_next;
   logic m_en;
   logic [BT_W-1:0] m_bt;
   logic [PC_W-1:0] m_pc;
   logic m_dir;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ret.delete(); pend.delete();
         m_next = 0; m_en = 0; m_bt = '0; m_pc = '0; m_dir = 0;
      end else begin
         automatic bit full_pre = (ret.size() + pend.size()) == DEPTH;
         automatic ent_t e;
         automatic int idx = -1;
         m_en = 0;
         if (ret.size() > 0) begin
            e = ret.pop_front();
            m_en = 1; m_bt = e.bt; m_pc = e.pc; m_dir = e.res ? e.rd : e.pd;
         end
         if (resolveEn_i) begin
            foreach (ret[i])  if (ret[i].id == int'(resolveID_i))  begin ret[i].rd = resolveDir_i;  ret[i].res = 1; end
            foreach (pend[i]) if (pend[i].id == int'(resolveID_i)) begin pend[i].rd = resolveDir_i; pend[i].res = 1; end
         end
         if (commitEn_i && pend.size() > 0) ret.push_back(pend.pop_front());
         if (exceptionFlag_i) begin
            m_next = (m_next - pend.size() + DEPTH) % DEPTH;
            pend.delete();
         end else if (recoverFlag_i) begin
            foreach (pend[i]) if (pend[i].id == int'(recoverID_i)) idx = i;
            while (pend.size() > idx + 1) void'(pend.pop_back());
            m_next = (int'(recoverID_i) + 1) % DEPTH;
         end else if (enq_i && !full_pre) begin
            e.id = m_next; e.pc = enqPC_i; e.bt = enqBrType_i; e.pd = enqPredDir_i; e.rd = 0; e.res = 0;
            pend.push_back(e);
            m_next = (m_next + 1) % DEPTH;
         end
      end
   end

   logic [PC_W-1:0] upd_pcs[$];
   int              upd_cyc[$];
   int              cyc_cnt = 0;
   logic [INDEX:0]  inv_hc, inv_ht;

   always @(negedge clk) begin
      cyc_cnt++;
      chk("updateEn",  updateEn_o,     m_en);
      chk("updateBt",  updateBrType_o, m_bt);
      chk("updatePC",  updatePC_o,     m_pc);
      chk("updateDir", updateDir_o,    m_dir);
      chk("full",      full_o,  (ret.size() + pend.size()) == DEPTH);
      chk("empty",     empty_o, (ret.size() + pend.size()) == 0);
      chk("ctiID",     ctiID_o, m_next[INDEX-1:0]);
      if (reset_n) begin
         inv_hc = dut.cmt_q  - dut.head_q;
         inv_ht = dut.tail_q - dut.head_q;
         chk("ptr_invariant", (inv_hc <= inv_ht) && (inv_ht <= DEPTH), 1);
      end
      if (updateEn_o) begin
         upd_pcs.push_back(updatePC_o);
         upd_cyc.push_back(cyc_cnt);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
      enq_i = 0; resolveEn_i = 0; commitEn_i = 0; recoverFlag_i = 0; exceptionFlag_i = 0;
   endtask

   task automatic put(input logic [PC_W-1:0] pc, input logic [BT_W-1:0] bt, input logic pd);
      enq_i = 1; enqPC_i = pc; enqBrType_i = bt; enqPredDir_i = pd;
      cyc();
   endtask

   task automatic do_reset();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      // Two CTIs retire back-to-back and drain one cycle after each commit
      do_reset();
      chk("rst_empty", empty_o, 1);
      chk("rst_full", full_o, 0);
      chk("rst_ctiID", ctiID_o, 0);
      chk("rst_updEn", updateEn_o, 0);
      put(32'h1000, BT_CALL, 1'b1);
      put(32'h2000, BT_RETURN, 1'b1);
      commitEn_i = 1; cyc();
      chk("t1_noupd_yet", updateEn_o, 0);
      commitEn_i = 1; cyc();
      chk("t1_en0", updateEn_o, 1);
      chk("t1_bt0", updateBrType_o, BT_CALL);
      chk("t1_pc0", updatePC_o, 32'h1000);
      cyc();
      chk("t1_en1", updateEn_o, 1);
      chk("t1_bt1", updateBrType_o, BT_RETURN);
      chk("t1_pc1", updatePC_o, 32'h2000);
      cyc();
      chk("t1_en_off", updateEn_o, 0);
      chk("t1_pc_hold", updatePC_o, 32'h2000);

      // Fill to capacity, overflow attempt, then free one slot
      do_reset();
      for (int i = 0; i < DEPTH; i++) put(32'h3000 + 32'(4 * i), BT_COND, 1'b0);
      chk("t2_full", full_o, 1);
      chk("t2_tail", ctiID_o, 0);
      put(32'h9999_0000, BT_COND, 1'b0);
      chk("t2_full17", full_o, 1);
      chk("t2_tail17", ctiID_o, 0);
      commitEn_i = 1; cyc();
      chk("t2_full_c1", full_o, 1);
      cyc();
      chk("t2_full_c2", full_o, 0);
      chk("t2_drain_pc", updatePC_o, 32'h3000);

      // Resolve then recover on ID 2
      do_reset();
      upd_pcs.delete();
      for (int i = 0; i < 6; i++) put(32'h5000 + 32'(4 * i), BT_COND, 1'b0);
      resolveEn_i = 1; resolveID_i = 4'd2; resolveDir_i = 1; cyc();
      recoverFlag_i = 1; recoverID_i = 4'd2; cyc();
      chk("t3_ctiID", ctiID_o, 3);
      repeat (3) begin commitEn_i = 1; cyc(); end
      chk("t3_pc1", updatePC_o, 32'h5004);
      chk("t3_dir1", updateDir_o, 0);
      cyc();
      chk("t3_pc2", updatePC_o, 32'h5008);
      chk("t3_dir2", updateDir_o, 1);
      cyc();
      chk("t3_nupd", upd_pcs.size(), 3);
      chk("t3_first", upd_pcs[0], 32'h5000);
      chk("t3_empty", empty_o, 1);

      // Exception after two of four retire
      do_reset();
      upd_pcs.delete();
      for (int i = 0; i < 4; i++) put(32'h6000 + 32'(4 * i), BT_COND, 1'b1);
      commitEn_i = 1; cyc();
      commitEn_i = 1; cyc();
      exceptionFlag_i = 1; cyc();
      chk("t4_ctiID", ctiID_o, 2);
      repeat (2) cyc();
      chk("t4_nupd", upd_pcs.size(), 2);
      chk("t4_empty", empty_o, 1);
      chk("t4_next_id", ctiID_o, 2);

      // Stream 40 CTIs through, crossing the pointer wrap
      upd_pcs.delete(); upd_cyc.delete();
      for (int k = 0; k < 40; k++) begin
         enq_i = 1; enqPC_i = 32'h4000 + 32'(4 * k); enqBrType_i = BT_COND; enqPredDir_i = 0;
         commitEn_i = (k > 0);
         cyc();
      end
      commitEn_i = 1; cyc();
      repeat (3) cyc();
      chk("t5_nupd", upd_pcs.size(), 40);
      bad = 0;
      for (int k = 0; k < upd_pcs.size(); k++) if (upd_pcs[k] !== 32'h4000 + 32'(4 * k)) bad++;
      chk("t5_order", bad, 0);
      chk("t5_nogap", (upd_cyc.size() == 40) ? upd_cyc[39] - upd_cyc[0] : -1, 39);
      chk("t5_empty", empty_o, 1);

      // Asynchronous reset while draining with a half-full queue
      do_reset();
      for (int i = 0; i < 9; i++) put(32'h7000 + 32'(4 * i), BT_CALL, 1'b1);
      commitEn_i = 1; cyc();
      cyc();
      chk("t6_pre_en", updateEn_o, 1);
      reset_n = 0;
      #1;
      chk("t6_rst_en", updateEn_o, 0);
      chk("t6_rst_bt", updateBrType_o, 0);
      chk("t6_rst_pc", updatePC_o, 0);
      chk("t6_rst_dir", updateDir_o, 0);
      chk("t6_rst_full", full_o, 0);
      chk("t6_rst_empty", empty_o, 1);
      chk("t6_rst_id", ctiID_o, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      enq_i = 1; enqPC_i = 32'h8000; enqBrType_i = BT_CALL; enqPredDir_i = 0;
      #1 chk("t6_first_id", ctiID_o, 0);
      cyc();
      chk("t6_next_id", ctiID_o, 1);
      repeat (2) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cti_commit_queue.md
Name: cti_commit_queue

Overview:
- In-order queue of control-transfer instructions (CTIs), written by fetch stage 2.
- Holds each CTI until it retires, then drives one non-speculative update per cycle into the RAS and branch predictors (updateEn_o / updateBrType_o / updatePC_o).
- This queue is the producer of the RAS architectural-update interface.
- Entries younger than a mispredicted CTI are dropped on recovery. All unretired entries are dropped on exception.

Parameters:
- DEPTH, 16, number of queue entries (power of two).
- INDEX, 4, log2(DEPTH).
- PC_W, 32, PC width (`SIZE_PC).
- BT_W, 2, branch-type width (`BRANCH_TYPE_LOG); encodings are the codebase's `CALL / `RETURN / `JUMP / `COND.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enq_i  in  1  fetch stage 2 presents a CTI.
- enqPC_i  in  PC_W  CTI PC.
- enqBrType_i  in  BT_W  CTI branch type.
- enqPredDir_i  in  1  predicted direction.
- ctiID_o  out  INDEX  ID assigned to the CTI presented this cycle (current tail index).
- full_o  out  1  queue cannot accept an enqueue.
- resolveEn_i  in  1  execute resolves a CTI.
- resolveID_i  in  INDEX  ID of the resolved CTI.
- resolveDir_i  in  1  actual direction.
- commitEn_i  in  1  the oldest unretired CTI retires this cycle.
- recoverFlag_i  in  1  misprediction recovery.
- recoverID_i  in  INDEX  ID of the mispredicted CTI (kept in the queue).
- exceptionFlag_i  in  1  exception flush.
- updateEn_o  out  1  architectural update valid.
- updateBrType_o  out  BT_W  type of the CTI being updated.
- updatePC_o  out  PC_W  PC of the CTI being updated.
- updateDir_o  out  1  resolved direction (predicted direction if never resolved).
- empty_o  out  1  no valid entries.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0:
  - head, commitPtr and tail pointers are 0.
  - Count registers are 0.
  - updateEn_o=0, updateBrType_o=0, updatePC_o=0, updateDir_o=0.
  - full_o=0, empty_o=1.
- Pointers are INDEX+1 bits; the MSB is a wrap bit.
  - full_o = (tail−head == DEPTH).
  - empty_o = (tail == head).
  - ctiID_o = tail[INDEX−1:0], combinational.
- Enqueue: when enq_i & ~full_o & ~recoverFlag_i & ~exceptionFlag_i, write {PC, type, predDir, resolved=0} at tail and increment tail.
  - enq_i while full is dropped; the fetch stage must stall on full_o.
- Resolve: when resolveEn_i, write the direction into the entry at resolveID_i and set its resolved bit. This is allowed in the same cycle as a recover of an older ID; the write is harmless.
- Commit: when commitEn_i & (commitPtr != tail), increment commitPtr.
  - commitEn_i while commitPtr==tail is ignored.
  - A commit of the entry being enqueued in the same cycle is not possible, because the entry is not yet visible.
- Update drain:
  - Each cycle, if head != commitPtr, register the head entry onto the update outputs, assert updateEn_o for exactly 1 cycle, and increment head.
  - Otherwise updateEn_o=0; the data outputs hold their previous values.
  - Latency: a commit in cycle N gives updateEn_o in cycle N+1 at the earliest.
  - Throughput: 1 update per cycle. A backlog drains at 1 entry per cycle.
- Recovery (recoverFlag_i):
  - tail := pointer of recoverID_i + 1, with the wrap bit derived so that the result is ≥ commitPtr.
  - The entry at recoverID_i, if unresolved, is left resolved=0.
  - Head and commitPtr are unaffected.
  - A commit and update in the same cycle both proceed.
- Exception (exceptionFlag_i):
  - tail := commitPtr, after applying any same-cycle commit.
  - Already-retired entries still drain.
  - If exceptionFlag_i and recoverFlag_i are both high, exception wins.
- Priority within a cycle: exception > recover > enqueue. Commit and drain are independent of the flush.
- Wrap-around: all pointer arithmetic is modulo 2·DEPTH.
  - No entry is ever overwritten while its index lies in [head, tail).
- Invariant: head ≤ commitPtr ≤ tail, modulo the wrap rules. A bench assertion must check it every cycle.

Test Plan:
- Enqueue CALL PC=0x1000, then RETURN PC=0x2000; commit both in consecutive cycles. Required: updateEn_o high 2 cycles, first with type=`CALL, PC=0x1000, then `RETURN, 0x2000, each one cycle after its commit.
- Enqueue 16 CTIs with no commit. Required: full_o=1 after the 16th; a 17th enq_i leaves tail unchanged. Then commit 1: full_o=0 two cycles later, after the drain.
- Enqueue IDs 0..5; resolve ID 2 with dir=1; recover with recoverID_i=2. Required: tail=3, ctiID_o=3. Commit 3 times: updates for IDs 0,1,2, and ID 2 has updateDir_o=1.
- Enqueue 4 CTIs, commit 2, assert exceptionFlag_i. Required: exactly 2 updates, empty_o=1 after the drain, next ctiID_o=2.
- Wrap: cycle 40 CTIs through with 1-cycle enqueue→commit spacing. Required: PCs 0x4000+4·k are emitted in order, no gaps, and empty_o=1 at the end.
- Assert reset_n low while updateEn_o=1 and the queue is half full. Required: all outputs go to their reset values immediately; after release, the first enqueue gets ctiID_o=0.
